// File: rtl/cpu_mem_pkg.sv
// Shared types and defaults for the CPU memory responder.
// Contents: responder state enum, default geometry constants, bus direction codes.
package cpu_mem_pkg;

  localparam int unsigned DEF_ADDR_W   = 10;
  localparam int unsigned DEF_DATA_W   = 16;
  localparam int unsigned DEF_PROG_END = 400;
  localparam int unsigned DEF_CNT_W    = 32;

  // CPU bus read_write encoding
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

endpackage

// File: rtl/cpu_mem_array.sv
// Single-port synchronous RAM, 2**ADDR_W x DATA_W, registered read.
// Ports:
//   clk, reset        - clock; reset clears only the read register, never the array
//   we_i, re_i        - write / read enables (mutually exclusive by construction upstream)
//   addr_i, wdata_i   - shared address and write data
//   rdata_o           - registered read data, holds between reads
module cpu_mem_array #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read register, only updated on a read so the last value is held
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu_memory_responder.sv
// Memory-side responder for the CPU bus: host loads memory in LOAD, CPU runs
// against it in RUN while run cycles are counted, host dumps it in HALT.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   read_write, memory_address,
//   data_out, data_in                - CPU memory bus (data_in = read data to CPU)
//   start_end, cpu_enable            - CPU running flag in, CPU release out
//   host_valid/ready/write/addr/
//   wdata/rdata/rvalid               - host load/dump port
//   host_go, done                    - start pulse, halted indication
//   cycle_count                      - saturating RUN cycle counter
//   wr_violation                     - sticky program-region write attempt flag
// Optional feature macro: CPU_MEM_WRPROT_EN (CPU write protection of the
// program region 0..PROG_END; without it wr_violation is tied low).
module cpu_memory_responder
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned PROG_END = DEF_PROG_END,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read_write,
  input  logic [ADDR_W-1:0] memory_address,
  input  logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] data_in,
  input  logic              start_end,
  output logic              cpu_enable,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_write,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              host_go,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_count,
  output logic              wr_violation
);

`ifdef CPU_MEM_WRPROT_EN
  localparam bit WRPROT_EN = 1'b1;
`else
  localparam bit WRPROT_EN = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] PROG_END_A = ADDR_W'(PROG_END);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  state_e state_q, state_d;

  logic              cpu_enable_q;
  logic              done_q;
  logic              host_ready_q;
  logic              host_rvalid_q, host_rvalid_d;
  logic [CNT_W-1:0]  cycle_count_q;

  logic              mem_we_c;
  logic              mem_re_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] mem_rdata;

  logic in_prog_c;
  logic cpu_wr_block_c;

  assign in_prog_c      = (memory_address <= PROG_END_A);
  assign cpu_wr_block_c = WRPROT_EN & in_prog_c;

  // State register and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= LOAD;
      cpu_enable_q  <= 1'b0;
      done_q        <= 1'b0;
      host_ready_q  <= 1'b1;
      host_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cpu_enable_q  <= (state_d == RUN);
      done_q        <= (state_d == HALT);
      host_ready_q  <= (state_d != RUN);
      host_rvalid_q <= host_rvalid_d;
    end
  end

  // Next state and RAM port arbitration: host owns the port outside RUN
  always_comb begin
    state_d       = state_q;
    host_rvalid_d = 1'b0;
    mem_we_c      = 1'b0;
    mem_re_c      = 1'b0;
    mem_addr_c    = host_addr;
    mem_wdata_c   = host_wdata;

    case (state_q)
      LOAD, HALT: begin
        if (host_valid) begin
          mem_we_c      = host_write;
          mem_re_c      = ~host_write;
          host_rvalid_d = ~host_write;
        end
        if ((state_q == LOAD) && host_go) begin
          state_d = RUN;
        end
      end
      RUN: begin
        mem_addr_c  = memory_address;
        mem_wdata_c = data_out;
        if (read_write == RW_READ) begin
          mem_re_c = 1'b1;
        end else begin
          mem_we_c = ~cpu_wr_block_c;
        end
        if (!start_end) begin
          state_d = HALT;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase

    // Reset wins over any access in flight
    if (reset) begin
      mem_we_c = 1'b0;
      mem_re_c = 1'b0;
    end
  end

  // Run-cycle counter, saturating; frozen outside RUN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_q <= '0;
    end else if ((state_q == RUN) && (cycle_count_q != CNT_MAX)) begin
      cycle_count_q <= cycle_count_q + CNT_W'(1);
    end
  end

`ifdef CPU_MEM_WRPROT_EN
  logic wr_violation_q;

  // Sticky flag for suppressed CPU writes into the program region
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_violation_q <= 1'b0;
    end else if ((state_q == RUN) && (read_write == RW_WRITE) && cpu_wr_block_c) begin
      wr_violation_q <= 1'b1;
    end
  end

  assign wr_violation = wr_violation_q;
`else
  assign wr_violation = 1'b0;
`endif

  cpu_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .we_i    (mem_we_c),
    .re_i    (mem_re_c),
    .addr_i  (mem_addr_c),
    .wdata_i (mem_wdata_c),
    .rdata_o (mem_rdata)
  );

  // One read register serves both sides; only its owner's qualifier matters
  assign data_in     = mem_rdata;
  assign host_rdata  = mem_rdata;
  assign host_rvalid = host_rvalid_q;
  assign cpu_enable  = cpu_enable_q;
  assign done        = done_q;
  assign host_ready  = host_ready_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: doc/cpu_memory_responder.md
Name: cpu_memory_responder

Overview:
- Synthesizable memory-side responder for the CPU memory bus (read_write, memory_address, data_out → data_in).
- Holds 1024x16 program plus data storage. A host port loads memory before execution and dumps it after halt.
- Gates CPU execution and counts run cycles until the CPU drops start_end.

Parameters:
- ADDR_W, 10, memory address width (depth = 2**ADDR_W).
- DATA_W, 16, word width.
- PROG_END, 400, last address of the program region; data region is PROG_END+1..2**ADDR_W-1.
- CNT_W, 32, run-cycle counter width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- read_write  in  1  CPU bus direction: 0 = read, 1 = write.
- memory_address  in  ADDR_W  CPU bus address.
- data_out  in  DATA_W  CPU write data.
- data_in  out  DATA_W  CPU read data.
- start_end  in  1  CPU running flag; 0 = program finished.
- cpu_enable  out  1  releases the CPU; high only in RUN.
- host_valid  in  1  host access request.
- host_ready  out  1  host access accepted this cycle.
- host_write  in  1  host direction: 1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_rdata  out  DATA_W  host read data.
- host_rvalid  out  1  host_rdata valid (1 cycle after accepted read).
- host_go  in  1  single-cycle pulse: start execution.
- done  out  1  program halted; memory available for dump.
- cycle_count  out  CNT_W  number of RUN cycles.
- wr_violation  out  1  sticky flag: CPU write attempted into program region (WRPROT_EN only).

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - state = LOAD.
  - Outputs cleared: cpu_enable=0, done=0, host_rvalid=0, host_rdata=0, data_in=0, cycle_count=0, wr_violation=0.
  - Memory contents are NOT cleared. Reset mid-RUN or mid-HALT returns to LOAD and keeps contents.
- States: LOAD → RUN → HALT. Leave HALT only via reset.
- LOAD:
  - host_ready=1.
  - Accepted write (host_valid & host_write) commits on the same posedge.
  - Accepted read: host_rdata/host_rvalid one cycle later.
  - CPU bus ignored.
  - host_go → RUN next cycle. A host access in the same cycle as host_go completes first.
- RUN:
  - cpu_enable=1, host_ready=0; host requests are ignored, not queued.
  - Read (read_write=0): data_in = mem[memory_address] registered, 1-cycle latency; data_in holds its value on write cycles.
  - Write (read_write=1): mem[memory_address] = data_out at posedge.
  - Read of an address written in the previous cycle returns the new data. Read-during-write to the same address is impossible (single direction bit).
  - cycle_count increments each RUN cycle and saturates at all-ones.
  - start_end sampled 0 → HALT next cycle, including on the first RUN cycle. That cycle is still counted.
- HALT:
  - cpu_enable=0, done=1, cycle_count frozen.
  - host_ready=1, reads and writes allowed (dump).
  - host_go ignored.
- Address arithmetic: plain ADDR_W-bit indexing, no wrap logic; every address is valid.

Optional Feature:
- Macro: CPU_MEM_WRPROT_EN.
- Defined:
  - In RUN, CPU writes to addresses 0..PROG_END are suppressed (memory unchanged).
  - wr_violation set sticky; cleared only by reset.
  - Host writes are never protected.
- Undefined: all CPU writes commit and wr_violation is tied to 0.

Decomposition:
- Package cpu_mem_pkg:
  - state enum {LOAD, RUN, HALT}.
  - Default ADDR_W, DATA_W, PROG_END, CNT_W constants.
  - Bus direction constants RW_READ=0, RW_WRITE=1.
- Sub-module cpu_mem_array: single-port synchronous RAM, 2**ADDR_W x DATA_W, registered read, write-enable.
- Top block: owns state machine, port arbitration mux (host vs CPU by state), counter, protection check.

Test Plan:
- Load and dump: host writes 0x1234 to addr 5 and 0xBEEF to addr 401 in LOAD, then reads them → host_rvalid one cycle after each accept; host_rdata = 0x1234, then 0xBEEF.
- CPU read: LOAD mem[401]=0xA5A5, host_go, CPU drives read_write=0 and addr 401 → data_in = 0xA5A5 on the next posedge; cpu_enable=1 from the cycle after host_go.
- CPU write then halt: CPU writes 0x00FF to addr 402, start_end=0 after 10 RUN cycles → done=1, cycle_count=10 and frozen; host read of 402 returns 0x00FF.
- Host blocked in RUN: host_valid=1 with write to 403 during RUN → host_ready=0 and mem[403] unchanged after halt.
- Reset mid-RUN: reset at cycle 5 → state LOAD, cpu_enable=0, cycle_count=0, previously loaded mem[401] still 0xA5A5.
- Protection (CPU_MEM_WRPROT_EN): CPU writes 0xDEAD to addr 100 → mem[100] unchanged, wr_violation=1 and stays 1 until reset. Without the macro: mem[100]=0xDEAD and wr_violation=0.
